// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: request/response signals between the two masters, the arbiter and memory_top
//   slave  : arbiter view (takes master requests and memory responses, drives everything else)
//   master : environment view (masters and memory_top), the mirror of slave
//   i_mX_* / o_mX_* : master X request pulse + fields, response pulse + data + timeout flag
//   o_bus_* / i_bus_* : request pulse + fields to memory_top, response pulse + data back
//   o_protocol_err : dropped-request pulse; o_grant : owner of current/last transaction
interface mem_bus_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              i_m0_DV, i_m1_DV;
    logic [ADDR_W-1:0] i_m0_address, i_m1_address;
    logic [DATA_W-1:0] i_m0_data, i_m1_data;
    logic [2:0]        i_m0_bhw, i_m1_bhw;
    logic              i_m0_write_notread, i_m1_write_notread;
    logic              o_m0_DV, o_m1_DV;
    logic [DATA_W-1:0] o_m0_data, o_m1_data;
    logic              o_m0_err, o_m1_err;
    logic              o_bus_DV;
    logic [ADDR_W-1:0] o_bus_address;
    logic [DATA_W-1:0] o_bus_data;
    logic [2:0]        o_bhw;
    logic              o_write_notread;
    logic              i_bus_DV;
    logic [DATA_W-1:0] i_bus_data;
    logic              o_protocol_err;
    logic              o_grant;

    modport slave (
        input  i_m0_DV, i_m1_DV, i_m0_address, i_m1_address, i_m0_data, i_m1_data,
               i_m0_bhw, i_m1_bhw, i_m0_write_notread, i_m1_write_notread, i_bus_DV, i_bus_data,
        output o_m0_DV, o_m1_DV, o_m0_data, o_m1_data, o_m0_err, o_m1_err, o_bus_DV,
               o_bus_address, o_bus_data, o_bhw, o_write_notread, o_protocol_err, o_grant
    );

    modport master (
        output i_m0_DV, i_m1_DV, i_m0_address, i_m1_address, i_m0_data, i_m1_data,
               i_m0_bhw, i_m1_bhw, i_m0_write_notread, i_m1_write_notread, i_bus_DV, i_bus_data,
        input  o_m0_DV, o_m1_DV, o_m0_data, o_m1_data, o_m0_err, o_m1_err, o_bus_DV,
               o_bus_address, o_bus_data, o_bhw, o_write_notread, o_protocol_err, o_grant
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the memory_top DV-pulse request bus between master M0 and master M1
//   i_clk      : system clock
//   i_reset_n  : synchronous active-low reset
//   bus        : mem_bus_arbiter_if.slave carrying both master ports and the memory_top port
//   Optional macro ARB_ROUND_ROBIN_EN: alternate winner on ties; otherwise M0 always wins ties.
//   Responses that do not arrive within TIMEOUT_CYCLES wait cycles complete with 32'hDEADBEEF and err=1.
module mem_bus_arbiter #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              i_clk,
    input logic              i_reset_n,
    mem_bus_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q [2], addr_d [2];
    logic [DATA_W-1:0] wdata_q [2], wdata_d [2];
    logic [2:0]        bhw_q [2], bhw_d [2];
    logic [1:0]        wn_q, wn_d;
    logic              grant_q, grant_d;
    logic              bus_dv_q, bus_dv_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic [2:0]        bus_bhw_q, bus_bhw_d;
    logic              bus_wn_q, bus_wn_d;
    logic [1:0]        rsp_dv_q, rsp_dv_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q [2], rsp_data_d [2];
    logic              perr_q, perr_d;

    logic [1:0]        req_dv, req_wn, in_flight;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [2:0]        req_bhw [2];
    logic              winner, timeout;

    always_comb begin
        req_dv   = {bus.i_m1_DV, bus.i_m0_DV};
        req_wn   = {bus.i_m1_write_notread, bus.i_m0_write_notread};
        req_addr = '{bus.i_m0_address, bus.i_m1_address};
        req_data = '{bus.i_m0_data, bus.i_m1_data};
        req_bhw  = '{bus.i_m0_bhw, bus.i_m1_bhw};
    end

    // grant_q doubles as the round-robin pointer: it always names the last winner
`ifdef ARB_ROUND_ROBIN_EN
    assign winner = &pend_q ? ~grant_q : pend_q[1];
`else
    assign winner = ~pend_q[0];
`endif

    assign in_flight = {state_q != IDLE && grant_q, state_q != IDLE && !grant_q};
    assign timeout   = cnt_q == CNT_W'(TIMEOUT_CYCLES);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bhw_d      = bhw_q;
        wn_d       = wn_q;
        grant_d    = grant_q;
        bus_dv_d   = 1'b0;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        bus_bhw_d  = bus_bhw_q;
        bus_wn_d   = bus_wn_q;
        rsp_dv_d   = '0;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;
        perr_d     = 1'b0;
        if (state_q == IDLE && |pend_q) begin
            state_d        = ISSUE;
            pend_d[winner] = 1'b0;
            grant_d        = winner;
            bus_dv_d       = 1'b1;
            bus_addr_d     = addr_q[winner];
            bus_data_d     = wdata_q[winner];
            bus_bhw_d      = bhw_q[winner];
            bus_wn_d       = wn_q[winner];
        end else if (state_q == ISSUE) begin
            // the counter includes the current wait cycle, so timeout lands TIMEOUT_CYCLES after entry
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
        end else if (state_q == WAIT) begin
            if (bus.i_bus_DV || timeout) begin
                state_d             = IDLE;
                rsp_dv_d[grant_q]   = 1'b1;
                rsp_data_d[grant_q] = bus.i_bus_DV ? bus.i_bus_data : DATA_W'(32'hDEADBEEF);
                rsp_err_d[grant_q]  = !bus.i_bus_DV;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (req_dv[i]) begin
                if (pend_q[i] || in_flight[i]) begin
                    perr_d = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    addr_d[i]  = req_addr[i];
                    wdata_d[i] = req_data[i];
                    bhw_d[i]   = req_bhw[i];
                    wn_d[i]    = req_wn[i];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            addr_q     <= '{default: '0};
            wdata_q    <= '{default: '0};
            bhw_q      <= '{default: '0};
            wn_q       <= '0;
            grant_q    <= 1'b0;
            bus_dv_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_bhw_q  <= '0;
            bus_wn_q   <= 1'b0;
            rsp_dv_q   <= '0;
            rsp_err_q  <= '0;
            rsp_data_q <= '{default: '0};
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            bhw_q      <= bhw_d;
            wn_q       <= wn_d;
            grant_q    <= grant_d;
            bus_dv_q   <= bus_dv_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            bus_bhw_q  <= bus_bhw_d;
            bus_wn_q   <= bus_wn_d;
            rsp_dv_q   <= rsp_dv_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
            perr_q     <= perr_d;
        end
    end

    assign bus.o_bus_DV        = bus_dv_q;
    assign bus.o_bus_address   = bus_addr_q;
    assign bus.o_bus_data      = bus_data_q;
    assign bus.o_bhw           = bus_bhw_q;
    assign bus.o_write_notread = bus_wn_q;
    assign bus.o_m0_DV         = rsp_dv_q[0];
    assign bus.o_m1_DV         = rsp_dv_q[1];
    assign bus.o_m0_data       = rsp_data_q[0];
    assign bus.o_m1_data       = rsp_data_q[1];
    assign bus.o_m0_err        = rsp_err_q[0];
    assign bus.o_m1_err        = rsp_err_q[1];
    assign bus.o_protocol_err  = perr_q;
    assign bus.o_grant         = grant_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of mem_bus_arbiter against a transaction-level model
module tb_mem_bus_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus_if ();
    mem_bus_arbiter #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus_if)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  bhw;
        logic        wn;
    } req_t;

    req_t        m_req [2];
    bit          m_pend [2];
    int          m_owner = -1;
    int          m_age = 0;
    bit          m_last = 1'b0;
    logic        e_bus_dv = 1'b0;
    req_t        e_bus = '0;
    logic [1:0]  e_dv = '0, e_err = '0;
    logic [31:0] e_data [2];
    logic        e_perr = 1'b0, e_grant = 1'b0;

    logic [138:0] exp_v, dut_v;
    assign exp_v = {e_bus_dv, e_bus, e_dv, e_err, e_data[1], e_data[0], e_perr, e_grant};
    assign dut_v = {bus_if.o_bus_DV, bus_if.o_bus_address, bus_if.o_bus_data, bus_if.o_bhw,
                    bus_if.o_write_notread, bus_if.o_m1_DV, bus_if.o_m0_DV, bus_if.o_m1_err,
                    bus_if.o_m0_err, bus_if.o_m1_data, bus_if.o_m0_data, bus_if.o_protocol_err,
                    bus_if.o_grant};

    int checks = 0, passed = 0, cycle = 0;
    int mem_lat = 0, mem_cnt = 0;
    logic [31:0] mem_rdata = '0;

    // One clock edge of the arbiter described as transactions: each master holds at most one
    // outstanding request, one transaction owns the bus, and it completes on a reply or after TO wait cycles.
    function automatic void model_step();
        bit         old_pend [2];
        int         old_owner, w;
        req_t       inreq [2];
        logic [1:0] dv;
        if (!rst_n) begin
            m_pend = '{0, 0}; m_owner = -1; m_age = 0; m_last = 0;
            e_bus_dv = 0; e_bus = '0; e_dv = '0; e_err = '0; e_data = '{0, 0}; e_perr = 0; e_grant = 0;
            return;
        end
        old_pend  = m_pend;
        old_owner = m_owner;
        inreq[0]  = {bus_if.i_m0_address, bus_if.i_m0_data, bus_if.i_m0_bhw, bus_if.i_m0_write_notread};
        inreq[1]  = {bus_if.i_m1_address, bus_if.i_m1_data, bus_if.i_m1_bhw, bus_if.i_m1_write_notread};
        dv        = {bus_if.i_m1_DV, bus_if.i_m0_DV};
        e_bus_dv  = 0;
        e_dv      = '0;
        e_perr    = 0;
        if (old_owner >= 0) begin
            if (m_age >= 1 && bus_if.i_bus_DV) begin
                e_dv[old_owner] = 1; e_data[old_owner] = bus_if.i_bus_data; e_err[old_owner] = 0; m_owner = -1;
            end else if (m_age == TO) begin
                e_dv[old_owner] = 1; e_data[old_owner] = 32'hDEADBEEF; e_err[old_owner] = 1; m_owner = -1;
            end else begin
                m_age++;
            end
        end else if (old_pend[0] || old_pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = (old_pend[0] && old_pend[1]) ? (m_last ? 0 : 1) : (old_pend[0] ? 0 : 1);
`else
            w = old_pend[0] ? 0 : 1;
`endif
            m_pend[w] = 0; m_owner = w; m_age = 0; m_last = w[0];
            e_bus_dv = 1; e_bus = m_req[w]; e_grant = w[0];
        end
        for (int m = 0; m < 2; m++) begin
            if (dv[m]) begin
                if (old_pend[m] || old_owner == m) e_perr = 1;
                else begin m_pend[m] = 1; m_req[m] = inreq[m]; end
            end
        end
    endfunction

    // advance one clock: model tracks the edge, request pulses end, memory answers mem_lat cycles after a request
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        bus_if.i_m0_DV = 0;
        bus_if.i_m1_DV = 0;
        bus_if.i_bus_DV = 0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin bus_if.i_bus_DV = 1; bus_if.i_bus_data = mem_rdata; end
        end
        if (bus_if.o_bus_DV === 1'b1 && mem_lat > 0) mem_cnt = mem_lat;
        cycle++;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) begin
            cyc();
            checks++;
            if (dut_v !== '0) $display("FAIL reset cyc %0d: outputs %h required 0", cycle, dut_v);
            else passed++;
        end
        rst_n = 1;
    endtask

    task automatic test_single_read();
        int n;
        mem_lat = 5; mem_rdata = 32'h12345678;
        repeat (9) begin
            cyc();
            checks++;
            if (dut_v !== exp_v) $display("FAIL idle cyc %0d: outputs %h required %h", cycle, dut_v, exp_v);
            else passed++;
        end
        bus_if.i_m0_DV = 1; bus_if.i_m0_address = 32'h0000_1000; bus_if.i_m0_data = '0;
        bus_if.i_m0_bhw = 3'b010; bus_if.i_m0_write_notread = 0;
        cyc();
        checks++;
        if (bus_if.o_bus_DV !== 1'b0) $display("FAIL read_capture: o_bus_DV %b required 0", bus_if.o_bus_DV);
        else passed++;
        cyc();
        checks++;
        if ({bus_if.o_bus_DV, bus_if.o_bus_address, bus_if.o_write_notread, bus_if.o_grant} !== {1'b1, 32'h1000, 1'b0, 1'b0})
            $display("FAIL read_issue: dv/addr/wn/grant %b/%h/%b/%b required 1/00001000/0/0",
                     bus_if.o_bus_DV, bus_if.o_bus_address, bus_if.o_write_notread, bus_if.o_grant);
        else passed++;
        n = 0;
        while (bus_if.o_m0_DV !== 1'b1 && n < 20) begin
            cyc(); n++;
            checks++;
            if (dut_v !== exp_v) $display("FAIL read cyc %0d: outputs %h required %h", cycle, dut_v, exp_v);
            else passed++;
        end
        checks++;
        if ({n, bus_if.o_m0_data, bus_if.o_m0_err, bus_if.o_grant} !== {32'd6, 32'h12345678, 1'b0, 1'b0})
            $display("FAIL read_response: latency %0d data %h err %b grant %b required 6 12345678 0 0",
                     n, bus_if.o_m0_data, bus_if.o_m0_err, bus_if.o_grant);
        else passed++;
    endtask

    task automatic test_simultaneous();
        logic order [$];
        logic exp_first;
        repeat (2) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_first = !m_last;
`else
            exp_first = 1'b0;
`endif
            order = {};
            mem_lat = 3; mem_rdata = $urandom;
            bus_if.i_m0_DV = 1; bus_if.i_m0_address = $urandom; bus_if.i_m0_write_notread = 0;
            bus_if.i_m1_DV = 1; bus_if.i_m1_address = $urandom; bus_if.i_m1_write_notread = 0;
            repeat (20) begin
                cyc();
                if (bus_if.o_bus_DV === 1'b1) order.push_back(bus_if.o_grant);
                checks++;
                if (dut_v !== exp_v) $display("FAIL simultaneous cyc %0d: outputs %h required %h", cycle, dut_v, exp_v);
                else passed++;
            end
            checks++;
            if (order.size() != 2 || order[0] !== exp_first || order[1] !== !exp_first)
                $display("FAIL simultaneous_order: grants %p required %0d then %0d", order, exp_first, !exp_first);
            else passed++;
        end
    endtask

    task automatic test_write();
        int n;
        mem_lat = 2; mem_rdata = 32'h0000_0001;
        bus_if.i_m1_DV = 1; bus_if.i_m1_address = 32'h8000_0004; bus_if.i_m1_data = 32'hCAFEBABE;
        bus_if.i_m1_bhw = 3'b010; bus_if.i_m1_write_notread = 1;
        cyc();
        cyc();
        checks++;
        if ({bus_if.o_bus_DV, bus_if.o_bus_address, bus_if.o_bus_data, bus_if.o_bhw, bus_if.o_write_notread, bus_if.o_grant}
            !== {1'b1, 32'h8000_0004, 32'hCAFEBABE, 3'b010, 1'b1, 1'b1})
            $display("FAIL write_issue: dv %b addr %h data %h bhw %b wn %b grant %b required 1 80000004 cafebabe 010 1 1",
                     bus_if.o_bus_DV, bus_if.o_bus_address, bus_if.o_bus_data, bus_if.o_bhw,
                     bus_if.o_write_notread, bus_if.o_grant);
        else passed++;
        n = 0;
        while (bus_if.o_m1_DV !== 1'b1 && n < 20) begin
            cyc(); n++;
            checks++;
            if (dut_v !== exp_v) $display("FAIL write cyc %0d: outputs %h required %h", cycle, dut_v, exp_v);
            else passed++;
        end
        checks++;
        if ({bus_if.o_m1_DV, bus_if.o_m1_err, bus_if.o_m0_DV, bus_if.o_m1_data} !== {1'b1, 1'b0, 1'b0, 32'h1})
            $display("FAIL write_ack: m1_dv %b err %b m0_dv %b data %h required 1 0 0 00000001",
                     bus_if.o_m1_DV, bus_if.o_m1_err, bus_if.o_m0_DV, bus_if.o_m1_data);
        else passed++;
        repeat (2) cyc();
    endtask

    task automatic test_timeout();
        int n;
        mem_lat = 0;
        bus_if.i_m0_DV = 1; bus_if.i_m0_address = 32'h0000_2000; bus_if.i_m0_write_notread = 0;
        cyc();
        cyc();
        n = 0;
        while (bus_if.o_m0_DV !== 1'b1 && n < 30) begin
            cyc(); n++;
            checks++;
            if (dut_v !== exp_v) $display("FAIL timeout cyc %0d: outputs %h required %h", cycle, dut_v, exp_v);
            else passed++;
        end
        checks++;
        if ({n, bus_if.o_m0_data, bus_if.o_m0_err} !== {32'd9, 32'hDEADBEEF, 1'b1})
            $display("FAIL timeout_response: cycles after issue %0d data %h err %b required 9 deadbeef 1",
                     n, bus_if.o_m0_data, bus_if.o_m0_err);
        else passed++;
        bus_if.i_bus_DV = 1; bus_if.i_bus_data = 32'h5555_AAAA;
        repeat (4) begin
            cyc();
            checks++;
            if (dut_v !== exp_v || bus_if.o_m0_DV !== 1'b0 || bus_if.o_m1_DV !== 1'b0)
                $display("FAIL late_reply cyc %0d: outputs %h required %h with no response pulse", cycle, dut_v, exp_v);
            else passed++;
        end
    endtask

    task automatic test_double_pulse();
        int bus_cnt, perr_cnt;
        bus_cnt = 0; perr_cnt = 0;
        mem_lat = 4; mem_rdata = 32'h0BAD_F00D;
        bus_if.i_m0_DV = 1; bus_if.i_m0_address = 32'h0000_3000;
        cyc();
        bus_if.i_m0_DV = 1; bus_if.i_m0_address = 32'h0000_3004;
        repeat (15) begin
            cyc();
            bus_cnt += int'(bus_if.o_bus_DV === 1'b1);
            perr_cnt += int'(bus_if.o_protocol_err === 1'b1);
            checks++;
            if (dut_v !== exp_v) $display("FAIL double_pulse cyc %0d: outputs %h required %h", cycle, dut_v, exp_v);
            else passed++;
        end
        checks++;
        if (bus_cnt != 1 || perr_cnt != 1)
            $display("FAIL double_pulse_counts: bus pulses %0d protocol_err cycles %0d required 1 1", bus_cnt, perr_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        mem_lat = 0;
        bus_if.i_m1_DV = 1; bus_if.i_m1_address = 32'h0000_4000; bus_if.i_m1_write_notread = 0;
        repeat (4) cyc();
        rst_n = 0;
        cyc();
        checks++;
        if (dut_v !== '0 || exp_v !== dut_v) $display("FAIL reset_mid: outputs %h required 0", dut_v);
        else passed++;
        rst_n = 1; mem_cnt = 0;
        bus_if.i_bus_DV = 1; bus_if.i_bus_data = 32'h7777_7777;
        repeat (5) begin
            cyc();
            checks++;
            if (dut_v !== exp_v || bus_if.o_m0_DV !== 1'b0 || bus_if.o_m1_DV !== 1'b0)
                $display("FAIL reset_mid_reply cyc %0d: outputs %h required %h with no response pulse", cycle, dut_v, exp_v);
            else passed++;
        end
    endtask

    task automatic test_random();
        repeat (500) begin
            bus_if.i_m0_DV = ($urandom_range(0, 3) == 0);
            bus_if.i_m0_address = $urandom; bus_if.i_m0_data = $urandom;
            bus_if.i_m0_bhw = 3'($urandom_range(0, 7)); bus_if.i_m0_write_notread = 1'($urandom_range(0, 1));
            bus_if.i_m1_DV = ($urandom_range(0, 3) == 0);
            bus_if.i_m1_address = $urandom; bus_if.i_m1_data = $urandom;
            bus_if.i_m1_bhw = 3'($urandom_range(0, 7)); bus_if.i_m1_write_notread = 1'($urandom_range(0, 1));
            mem_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO + 2);
            mem_rdata = $urandom;
            if ($urandom_range(0, 29) == 0) bus_if.i_bus_DV = 1;
            cyc();
            checks++;
            if (dut_v !== exp_v) $display("FAIL random cyc %0d: outputs %h required %h", cycle, dut_v, exp_v);
            else passed++;
        end
    endtask

    initial begin
        bus_if.i_m0_DV = 0; bus_if.i_m0_address = '0; bus_if.i_m0_data = '0;
        bus_if.i_m0_bhw = '0; bus_if.i_m0_write_notread = 0;
        bus_if.i_m1_DV = 0; bus_if.i_m1_address = '0; bus_if.i_m1_data = '0;
        bus_if.i_m1_bhw = '0; bus_if.i_m1_write_notread = 0;
        bus_if.i_bus_DV = 0; bus_if.i_bus_data = '0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_timeout();
        test_double_pulse();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
